ff_rr_arbiter: RTL

- Round-robin arbiter that shares one valid-qualified capture register among NUM_REQ requesters, such as the phase/sample producers feeding the firmware readout path.
- The block holds a single-entry registered output slot with ready/valid handshake on both sides.
- It grants one requester per cycle into the slot, tags the captured word with its source index, and counts completed output transfers for firmware bookkeeping.

---
 rtl/ff_rr_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/ff_rr_arbiter.sv
// rtl/ff_rr_arbiter.sv - round-robin arbiter into a single registered, source-tagged output slot
module ff_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int SRC_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ-1:0]            en_mask,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [CNT_WIDTH-1:0]          xfer_cnt
);

    logic [SRC_WIDTH-1:0]  rr_ptr;
    logic [NUM_REQ-1:0]    eligible;
    logic                  slot_free;
    logic                  found;
    logic [SRC_WIDTH-1:0]  win;
    logic [SRC_WIDTH-1:0]  win_next;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  accept;

    assign eligible  = req_vld & en_mask;
    assign slot_free = ~out_vld | out_rdy;
    assign accept    = rstn & slot_free & found;
    assign win_next  = (win == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : win + SRC_WIDTH'(1);

    // Two-pass scan: indices at or above rr_ptr first, then wrap to the bottom.
    // This keeps the wrap explicit for non-power-of-2 NUM_REQ.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i] && (SRC_WIDTH'(i) >= rr_ptr)) begin
                found    = 1'b1;
                win      = SRC_WIDTH'(i);
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i]) begin
                found    = 1'b1;
                win      = SRC_WIDTH'(i);
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = accept && (win == SRC_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data <= '0;
            out_src  <= '0;
            out_vld  <= 1'b0;
            xfer_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            if (out_vld && out_rdy) begin
                xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
            end
            if (slot_free) begin
                if (found) begin
                    out_data <= win_data;
                    out_src  <= win;
                    out_vld  <= 1'b1;
                    rr_ptr   <= win_next;
                end else begin
                    out_vld  <= 1'b0;
                end
            end
        end
    end

endmodule
